// File: rtl/demux4_7b_capture_pkg.sv
// Shared defaults and types for the four-slot 7-segment frame capture block.
package demux4_7b_capture_pkg;

   localparam int WIDTH = 7;
   localparam logic [WIDTH-1:0] BLANK = 7'h7F;

   typedef enum logic {
      COLLECT = 1'b0,
      COMMIT  = 1'b1
   } state_e;

   typedef logic [1:0] slot_idx_t;

   // In ordered mode the number of captured slots is the next slot we expect.
   function automatic logic [2:0] popcount4(input logic [3:0] mask);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, mask[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/demux4_7b_capture_slot.sv
// One frame slot: a shadow register filled by beats and an output register
// that only changes when the whole frame commits.
module demux_slot_7b
   import demux4_7b_capture_pkg::*;
#(
   parameter int                 WIDTH = demux4_7b_capture_pkg::WIDTH,
   parameter logic [WIDTH-1:0]   BLANK = demux4_7b_capture_pkg::BLANK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             commit_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] out_o
);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] out_q, out_d;

   // The completing beat commits in the same edge it loads, so bypass the
   // shadow for the slot that is being written right now.
   always_comb begin
      shadow_d = shadow_q;
      out_d    = out_q;
      if (load_i) begin
         shadow_d = din_i;
      end
      if (commit_i) begin
         out_d = load_i ? din_i : shadow_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q <= '0;
         out_q    <= BLANK;
      end else begin
         shadow_q <= shadow_d;
         out_q    <= out_d;
      end
   end

   assign out_o = out_q;

endmodule

// File: rtl/demux4_7b_capture.sv
// Collects four time-multiplexed 7-segment slots into a frame and publishes
// the frame atomically, flagging out-of-sequence beats.
module demux4_7b_capture
   import demux4_7b_capture_pkg::*;
#(
   parameter int               WIDTH        = demux4_7b_capture_pkg::WIDTH,
   parameter logic [WIDTH-1:0] BLANK        = demux4_7b_capture_pkg::BLANK,
   parameter int               STRICT_ORDER = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             s0,
   input  logic             s1,
   input  logic             valid,
   output logic             ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic             frame_valid,
   output logic             seq_err,
   output logic [7:0]       frame_cnt
);

   state_e     state_q, state_d;
   logic [3:0] mask_q, mask_d;
   logic       seqErr_q, seqErr_d;
   logic       frameValid_q, frameValid_d;
   logic [7:0] frameCnt_q, frameCnt_d;
   logic [3:0] loadVec;
   logic       commit;
   slot_idx_t  beatIdx;
   logic [3:0] beatHot;

   logic [WIDTH-1:0] slotOut [4];

   assign beatIdx = {s1, s0};
   assign beatHot = 4'b0001 << beatIdx;

   // Next-state logic: beats are only accepted in COLLECT, and COMMIT always
   // lasts exactly one cycle before collection resumes with an empty mask.
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      seqErr_d     = 1'b0;
      frameValid_d = 1'b0;
      frameCnt_d   = frameCnt_q;
      loadVec      = 4'b0000;
      commit       = 1'b0;
      unique case (state_q)
         COLLECT: begin
            if (valid) begin
               if (STRICT_ORDER != 0) begin
                  if ({1'b0, beatIdx} != popcount4(mask_q)) begin
                     seqErr_d = 1'b1;
                     mask_d   = 4'b0000;
                     if (beatIdx == 2'd0) begin
                        mask_d  = 4'b0001;
                        loadVec = 4'b0001;
                     end
                  end else begin
                     mask_d  = mask_q | beatHot;
                     loadVec = beatHot;
                  end
               end else begin
                  loadVec = beatHot;
                  if ((mask_q & beatHot) != 4'b0000) begin
                     seqErr_d = 1'b1;
                     mask_d   = beatHot;
                  end else begin
                     mask_d = mask_q | beatHot;
                  end
               end
               if (mask_d == 4'b1111) begin
                  state_d      = COMMIT;
                  commit       = 1'b1;
                  frameValid_d = 1'b1;
                  frameCnt_d   = frameCnt_q + 8'd1;
               end
            end
         end
         COMMIT: begin
            mask_d  = 4'b0000;
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= COLLECT;
         mask_q       <= 4'b0000;
         seqErr_q     <= 1'b0;
         frameValid_q <= 1'b0;
         frameCnt_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         seqErr_q     <= seqErr_d;
         frameValid_q <= frameValid_d;
         frameCnt_q   <= frameCnt_d;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : gSlot
      demux_slot_7b #(
         .WIDTH (WIDTH),
         .BLANK (BLANK)
      ) uSlot (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_i   (loadVec[g]),
         .commit_i (commit),
         .din_i    (din),
         .out_o    (slotOut[g])
      );
   end

   assign ready       = (state_q == COLLECT);
   assign out_a       = slotOut[0];
   assign out_b       = slotOut[1];
   assign out_c       = slotOut[2];
   assign out_d       = slotOut[3];
   assign frame_valid = frameValid_q;
   assign seq_err     = seqErr_q;
   assign frame_cnt   = frameCnt_q;

endmodule

// File: tb/tb_demux4_7b_capture.sv
// Scoreboard bench for demux4_7b_capture: one ordered instance, one any-order instance.
module tb_demux4_7b_capture;

   typedef struct packed {
      logic [6:0] a;
      logic [6:0] b;
      logic [6:0] c;
      logic [6:0] d;
      logic [7:0] cnt;
   } frame_t;

   localparam frame_t BLANK_FRAME = {{4{7'h7F}}, 8'h00};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] din = 7'h00;
   logic       s0 = 1'b0;
   logic       s1 = 1'b0;
   logic       valid = 1'b0;

   logic       readyS, fvS, seS;
   logic [6:0] outAS, outBS, outCS, outDS;
   logic [7:0] cntS;
   logic       readyA, fvA, seA;
   logic [6:0] outAA, outBA, outCA, outDA;
   logic [7:0] cntA;

   frame_t obsStrict, obsAny;
   assign obsStrict = {outAS, outBS, outCS, outDS, cntS};
   assign obsAny    = {outAA, outBA, outCA, outDA, cntA};

   frame_t     expQ[$];
   logic [7:0] expCnt = 8'd0;
   int         assertCount = 0;
   int         failCount = 0;

   always #5 clk = ~clk;

   demux4_7b_capture #(.STRICT_ORDER(1)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .s0(s0), .s1(s1), .valid(valid),
      .ready(readyS), .out_a(outAS), .out_b(outBS), .out_c(outCS), .out_d(outDS),
      .frame_valid(fvS), .seq_err(seS), .frame_cnt(cntS)
   );

   demux4_7b_capture #(.STRICT_ORDER(0)) dutAny (
      .clk(clk), .rst_n(rst_n), .din(din), .s0(s0), .s1(s1), .valid(valid),
      .ready(readyA), .out_a(outAA), .out_b(outBA), .out_c(outCA), .out_d(outDA),
      .frame_valid(fvA), .seq_err(seA), .frame_cnt(cntA)
   );

   // Drives both instances through a synchronous reset and clears the model.
   task automatic applyReset();
      rst_n = 1'b0;
      valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      expCnt = 8'd0;
      expQ.delete();
   endtask

   // Offers one beat for one edge; returns #1 after that edge.
   task automatic driveBeat(input logic [1:0] idx, input logic [6:0] d);
      valid = 1'b1;
      {s1, s0} = idx;
      din = d;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic pushFrame(input logic [6:0] a, input logic [6:0] b,
                            input logic [6:0] c, input logic [6:0] d);
      expCnt = expCnt + 8'd1;
      expQ.push_back(frame_t'({a, b, c, d, expCnt}));
   endtask

   task automatic waitFrame(input bit anyOrder, output bit seen);
      int i;
      seen = 1'b0;
      i = 0;
      while (!seen && i < 8) begin
         if ((anyOrder ? fvA : fvS) === 1'b1) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            i++;
         end
      end
   endtask

   task automatic test_reset();
      applyReset();
      assertCount++; if (obsStrict !== BLANK_FRAME) begin failCount++; $display("[TB] FAIL reset_outs_strict: got %h expected %h", obsStrict, BLANK_FRAME); end
      assertCount++; if (obsAny !== BLANK_FRAME) begin failCount++; $display("[TB] FAIL reset_outs_any: got %h expected %h", obsAny, BLANK_FRAME); end
      assertCount++; if (readyS !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready_strict: got %b expected 1", readyS); end
      assertCount++; if (readyA !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready_any: got %b expected 1", readyA); end
      assertCount++; if ({fvS, seS} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_pulses_strict: got %b expected 00", {fvS, seS}); end
      assertCount++; if ({fvA, seA} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_pulses_any: got %b expected 00", {fvA, seA}); end
   endtask

   task automatic test_ordered();
      frame_t exp;
      bit     seen;
      applyReset();
      pushFrame(7'h40, 7'h79, 7'h24, 7'h30);
      driveBeat(2'd0, 7'h40);
      driveBeat(2'd1, 7'h79);
      driveBeat(2'd2, 7'h24);
      assertCount++; if ({fvS, readyS} !== 2'b01) begin failCount++; $display("[TB] FAIL ordered_partial: got fv/ready %b expected 01", {fvS, readyS}); end
      driveBeat(2'd3, 7'h30);
      waitFrame(1'b0, seen);
      assertCount++; if (seen !== 1'b1) begin failCount++; $display("[TB] FAIL ordered_timeout: got no frame_valid expected one"); end
      exp = expQ.pop_front();
      assertCount++; if (obsStrict !== exp) begin failCount++; $display("[TB] FAIL ordered_frame: got %h expected %h", obsStrict, exp); end
      assertCount++; if ({readyS, seS} !== 2'b00) begin failCount++; $display("[TB] FAIL ordered_commit_ready: got ready/err %b expected 00", {readyS, seS}); end
      @(posedge clk); #1;
      assertCount++; if ({fvS, readyS} !== 2'b01) begin failCount++; $display("[TB] FAIL ordered_after: got fv/ready %b expected 01", {fvS, readyS}); end
      assertCount++; if (obsStrict !== exp) begin failCount++; $display("[TB] FAIL ordered_hold: got %h expected %h", obsStrict, exp); end
   endtask

   task automatic test_strict_order();
      frame_t exp;
      bit     seen;
      applyReset();
      driveBeat(2'd0, 7'h40);
      driveBeat(2'd2, 7'h24);
      assertCount++; if ({seS, fvS} !== 2'b10) begin failCount++; $display("[TB] FAIL strict_violation: got err/fv %b expected 10", {seS, fvS}); end
      @(posedge clk); #1;
      assertCount++; if (seS !== 1'b0) begin failCount++; $display("[TB] FAIL strict_err_pulse: got %b expected 0", seS); end
      assertCount++; if (obsStrict !== BLANK_FRAME) begin failCount++; $display("[TB] FAIL strict_outs_blank: got %h expected %h", obsStrict, BLANK_FRAME); end
      driveBeat(2'd1, 7'h79);
      assertCount++; if (seS !== 1'b1) begin failCount++; $display("[TB] FAIL strict_mask_cleared: got err %b expected 1", seS); end
      pushFrame(7'h19, 7'h12, 7'h02, 7'h78);
      driveBeat(2'd0, 7'h19);
      driveBeat(2'd1, 7'h12);
      driveBeat(2'd2, 7'h02);
      driveBeat(2'd3, 7'h78);
      waitFrame(1'b0, seen);
      assertCount++; if (seen !== 1'b1) begin failCount++; $display("[TB] FAIL strict_restart_timeout: got no frame_valid expected one"); end
      exp = expQ.pop_front();
      assertCount++; if (obsStrict !== exp) begin failCount++; $display("[TB] FAIL strict_restart_frame: got %h expected %h", obsStrict, exp); end
      @(posedge clk); #1;
      driveBeat(2'd0, 7'h0E);
      driveBeat(2'd1, 7'h0F);
      driveBeat(2'd0, 7'h46);
      assertCount++; if (seS !== 1'b1) begin failCount++; $display("[TB] FAIL strict_idx0_restart_err: got %b expected 1", seS); end
      pushFrame(7'h46, 7'h21, 7'h0C, 7'h08);
      driveBeat(2'd1, 7'h21);
      driveBeat(2'd2, 7'h0C);
      driveBeat(2'd3, 7'h08);
      waitFrame(1'b0, seen);
      assertCount++; if (seen !== 1'b1) begin failCount++; $display("[TB] FAIL strict_idx0_timeout: got no frame_valid expected one"); end
      exp = expQ.pop_front();
      assertCount++; if (obsStrict !== exp) begin failCount++; $display("[TB] FAIL strict_idx0_frame: got %h expected %h", obsStrict, exp); end
   endtask

   task automatic test_any_order();
      frame_t exp;
      bit     seen;
      applyReset();
      pushFrame(7'h40, 7'h79, 7'h24, 7'h30);
      driveBeat(2'd3, 7'h30);
      driveBeat(2'd1, 7'h79);
      driveBeat(2'd0, 7'h40);
      assertCount++; if ({seA, fvA} !== 2'b00) begin failCount++; $display("[TB] FAIL any_partial: got err/fv %b expected 00", {seA, fvA}); end
      driveBeat(2'd2, 7'h24);
      waitFrame(1'b1, seen);
      assertCount++; if (seen !== 1'b1) begin failCount++; $display("[TB] FAIL any_timeout: got no frame_valid expected one"); end
      exp = expQ.pop_front();
      assertCount++; if (obsAny !== exp) begin failCount++; $display("[TB] FAIL any_frame: got %h expected %h", obsAny, exp); end
      @(posedge clk); #1;
      driveBeat(2'd0, 7'h11);
      driveBeat(2'd1, 7'h22);
      driveBeat(2'd1, 7'h33);
      assertCount++; if ({seA, fvA} !== 2'b10) begin failCount++; $display("[TB] FAIL any_duplicate: got err/fv %b expected 10", {seA, fvA}); end
      pushFrame(7'h44, 7'h33, 7'h55, 7'h66);
      driveBeat(2'd0, 7'h44);
      driveBeat(2'd2, 7'h55);
      driveBeat(2'd3, 7'h66);
      waitFrame(1'b1, seen);
      assertCount++; if (seen !== 1'b1) begin failCount++; $display("[TB] FAIL any_restart_timeout: got no frame_valid expected one"); end
      exp = expQ.pop_front();
      assertCount++; if (obsAny !== exp) begin failCount++; $display("[TB] FAIL any_restart_frame: got %h expected %h", obsAny, exp); end
   endtask

   task automatic test_back_to_back();
      frame_t exp;
      bit     seen;
      applyReset();
      pushFrame(7'h06, 7'h5B, 7'h4F, 7'h66);
      driveBeat(2'd0, 7'h06);
      driveBeat(2'd1, 7'h5B);
      driveBeat(2'd2, 7'h4F);
      driveBeat(2'd3, 7'h66);
      waitFrame(1'b0, seen);
      assertCount++; if (seen !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_first_timeout: got no frame_valid expected one"); end
      exp = expQ.pop_front();
      assertCount++; if (obsStrict !== exp) begin failCount++; $display("[TB] FAIL b2b_first_frame: got %h expected %h", obsStrict, exp); end
      pushFrame(7'h5A, 7'h6D, 7'h7D, 7'h07);
      driveBeat(2'd0, 7'h01);
      assertCount++; if ({seS, readyS} !== 2'b01) begin failCount++; $display("[TB] FAIL b2b_ignored: got err/ready %b expected 01", {seS, readyS}); end
      driveBeat(2'd0, 7'h5A);
      assertCount++; if (seS !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_no_err: got %b expected 0", seS); end
      driveBeat(2'd1, 7'h6D);
      driveBeat(2'd2, 7'h7D);
      driveBeat(2'd3, 7'h07);
      waitFrame(1'b0, seen);
      assertCount++; if (seen !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_second_timeout: got no frame_valid expected one"); end
      exp = expQ.pop_front();
      assertCount++; if (obsStrict !== exp) begin failCount++; $display("[TB] FAIL b2b_second_frame: got %h expected %h", obsStrict, exp); end
   endtask

   task automatic test_reset_priority();
      applyReset();
      driveBeat(2'd0, 7'h40);
      driveBeat(2'd1, 7'h79);
      driveBeat(2'd2, 7'h24);
      rst_n = 1'b0;
      driveBeat(2'd3, 7'h30);
      rst_n = 1'b1;
      assertCount++; if ({fvS, readyS} !== 2'b01) begin failCount++; $display("[TB] FAIL rstpri_pulse: got fv/ready %b expected 01", {fvS, readyS}); end
      assertCount++; if (obsStrict !== BLANK_FRAME) begin failCount++; $display("[TB] FAIL rstpri_outs: got %h expected %h", obsStrict, BLANK_FRAME); end
      @(posedge clk); #1;
      assertCount++; if (fvS !== 1'b0) begin failCount++; $display("[TB] FAIL rstpri_late_commit: got %b expected 0", fvS); end
      driveBeat(2'd1, 7'h79);
      assertCount++; if (seS !== 1'b1) begin failCount++; $display("[TB] FAIL rstpri_partial_discard: got err %b expected 1", seS); end
   endtask

   task automatic test_wrap();
      frame_t     exp;
      bit         seen;
      logic [6:0] v;
      applyReset();
      for (int f = 0; f < 256; f++) begin
         v = 7'(f);
         pushFrame(v, v ^ 7'h55, v + 7'd3, ~v);
         driveBeat(2'd0, v);
         driveBeat(2'd1, v ^ 7'h55);
         driveBeat(2'd2, v + 7'd3);
         driveBeat(2'd3, ~v);
         waitFrame(1'b0, seen);
         assertCount++; if (seen !== 1'b1) begin failCount++; $display("[TB] FAIL wrap_timeout: frame %0d got no frame_valid", f); end
         exp = expQ.pop_front();
         assertCount++; if (obsStrict !== exp) begin failCount++; $display("[TB] FAIL wrap_frame: frame %0d got %h expected %h", f, obsStrict, exp); end
         @(posedge clk); #1;
      end
      assertCount++; if (cntS !== 8'd0) begin failCount++; $display("[TB] FAIL wrap_count: got %0d expected 0", cntS); end
   endtask

   initial begin
      test_reset();
      test_ordered();
      test_strict_order();
      test_any_order();
      test_back_to_back();
      test_reset_priority();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
